// File: rtl/diff_rx_sched_if.sv
// rtl/diff_rx_sched_if.sv - decoded-code output handshake between diff_rx_sched and its consumer
// master drives the held code and line index, slave returns ready.
interface diff_rx_sched_if #(
  parameter int NUM_LINES = 4
);
  localparam int CHAN_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

  logic [25:0]       code_out;
  logic [CHAN_W-1:0] chan_out;
  logic              code_valid_out;
  logic              code_ready_in;

  modport master (
    output code_out,
    output chan_out,
    output code_valid_out,
    input  code_ready_in
  );

  modport slave (
    input  code_out,
    input  chan_out,
    input  code_valid_out,
    output code_ready_in
  );
endinterface

// File: rtl/diff_rx_sched.sv
// rtl/diff_rx_sched.sv - shares one pulse-width-code decoder between NUM_LINES idle-high lines
// Optional per-line grant mask under macro RX_SCHED_LINE_MASK_EN.
module diff_rx_sched #(
  parameter int NUM_LINES     = 4,
  parameter int HIGH_TIMEOUT  = 32,
  parameter int FRAME_TIMEOUT = 1024,
  parameter int DROP_W        = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic [NUM_LINES-1:0] lines_in,
`ifdef RX_SCHED_LINE_MASK_EN
  input  logic [NUM_LINES-1:0] line_mask_in,
`endif
  output logic                 dec_data_out,
  output logic                 dec_rst_out,
  input  logic [25:0]          dec_code_in,
  input  logic                 dec_new_code_in,
  diff_rx_sched_if.master      code_if,
  output logic                 busy_out,
  output logic [DROP_W-1:0]    drop_count_out
);

  localparam int CHAN_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int HCNT_W = $clog2(HIGH_TIMEOUT + 1);
  localparam int FCNT_W = $clog2(FRAME_TIMEOUT + 1);

  localparam logic [HCNT_W-1:0] HIGH_LIMIT  = HCNT_W'(HIGH_TIMEOUT);
  localparam logic [FCNT_W-1:0] FRAME_LIMIT = FCNT_W'(FRAME_TIMEOUT);
  localparam logic [CHAN_W:0]   NL_WIDE     = (CHAN_W + 1)'(NUM_LINES);
  localparam logic [CHAN_W-1:0] LAST_LINE   = CHAN_W'(NUM_LINES - 1);
  localparam logic [DROP_W-1:0] DROP_MAX    = '1;

  typedef enum logic [1:0] {SCAN, LOCK, RELEASE} state_t;

  state_t               state;
  logic [NUM_LINES-1:0] sync1, sync2, hist;
  logic [NUM_LINES-1:0] fall, elig;
  logic [CHAN_W-1:0]    rr_ptr, g, g_next, gnt_idx;
  logic                 gnt_found, lock_masked, sync_g;
  logic [HCNT_W-1:0]    high_cnt;
  logic [FCNT_W-1:0]    frame_cnt;
  logic                 fire, can_capture, timed_out;

  assign fall   = hist & ~sync2;
  assign sync_g = sync2[g];
  assign g_next = (g == LAST_LINE) ? '0 : g + 1'b1;

`ifdef RX_SCHED_LINE_MASK_EN
  assign elig        = fall & ~line_mask_in;
  assign lock_masked = line_mask_in[g];
`else
  assign elig        = fall;
  assign lock_masked = 1'b0;
`endif

  assign fire        = code_if.code_valid_out & code_if.code_ready_in;
  assign can_capture = ~code_if.code_valid_out | code_if.code_ready_in;
  assign timed_out   = (high_cnt == HIGH_LIMIT) | (frame_cnt == FRAME_LIMIT) | lock_masked;

  // Round-robin search: first eligible fall at or after rr_ptr, wrapping.
  always_comb begin
    logic [CHAN_W:0] sum;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sum       = '0;
    for (int k = 0; k < NUM_LINES; k++) begin
      sum = {1'b0, rr_ptr} + (CHAN_W + 1)'(k);
      if (sum >= NL_WIDE) sum = sum - NL_WIDE;
      if (!gnt_found && elig[sum[CHAN_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = sum[CHAN_W-1:0];
      end
    end
  end

  // Idle-high reset values keep the first sampled cycle from looking like a fall.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync1 <= '1;
      sync2 <= '1;
      hist  <= '1;
    end else begin
      sync1 <= lines_in;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state                  <= SCAN;
      rr_ptr                 <= '0;
      g                      <= '0;
      high_cnt               <= '0;
      frame_cnt              <= '0;
      dec_data_out           <= 1'b1;
      dec_rst_out            <= 1'b1;
      busy_out               <= 1'b0;
      drop_count_out         <= '0;
      code_if.code_out       <= '0;
      code_if.chan_out       <= '0;
      code_if.code_valid_out <= 1'b0;
    end else begin
      if (fire) code_if.code_valid_out <= 1'b0;

      case (state)
        SCAN: begin
          dec_rst_out  <= 1'b0;
          dec_data_out <= 1'b1;
          if (gnt_found) begin
            g            <= gnt_idx;
            state        <= LOCK;
            busy_out     <= 1'b1;
            high_cnt     <= '0;
            frame_cnt    <= '0;
            dec_data_out <= sync2[gnt_idx];
          end
        end

        LOCK: begin
          dec_data_out <= sync_g;
          frame_cnt    <= frame_cnt + 1'b1;
          high_cnt     <= sync_g ? high_cnt + 1'b1 : '0;
          if (dec_new_code_in) begin
            // A capture in the same cycle as a handshake keeps valid asserted.
            if (can_capture) begin
              code_if.code_out       <= dec_code_in;
              code_if.chan_out       <= g;
              code_if.code_valid_out <= 1'b1;
            end else if (drop_count_out != DROP_MAX) begin
              drop_count_out <= drop_count_out + 1'b1;
            end
            rr_ptr   <= g_next;
            state    <= SCAN;
            busy_out <= 1'b0;
          end else if (timed_out) begin
            rr_ptr       <= g_next;
            state        <= RELEASE;
            dec_rst_out  <= 1'b1;
            dec_data_out <= 1'b1;
          end
        end

        RELEASE: begin
          dec_rst_out  <= 1'b0;
          dec_data_out <= 1'b1;
          state        <= SCAN;
          busy_out     <= 1'b0;
        end

        default: begin
          state    <= SCAN;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/diff_rx_sched.md
Name: diff_rx_sched

Overview:
- Shares one pulse-width-code receiver (26-bit frames; sync low/high half-periods, 0/1 bits as quarter/three-quarter low/high splits, idle-high line) between NUM_LINES input lines.
- Watches all lines, locks onto the first line to start a frame (round-robin priority) and steers it into the decoder.
- Releases the decoder on frame completion or timeout.
- Presents each decoded code, tagged with its line index, on a valid/ready output holding register.

Parameters:
- NUM_LINES, 4, number of shared input lines (2..16)
- HIGH_TIMEOUT, 32, max cycles a locked line may stay high without a completed code before release
- FRAME_TIMEOUT, 1024, max cycles from grant to release
- DROP_W, 8, width of saturating drop counter

Ports:
- clk_in  input  1  clock
- rst_n_in  input  1  asynchronous, active-low reset
- lines_in  input  NUM_LINES  raw idle-high code lines (asynchronous)
- dec_data_out  output  1  steered line to decoder data input
- dec_rst_out  output  1  active-high decoder reset
- dec_code_in  input  26  decoder code output
- dec_new_code_in  input  1  decoder one-cycle new-code strobe
- code_out  output  26  held code
- chan_out  output  $clog2(NUM_LINES)  line index of code_out
- code_valid_out  output  1  code_out/chan_out valid
- code_ready_in  input  1  consumer accepts when valid&ready
- busy_out  output  1  high while state != SCAN
- drop_count_out  output  DROP_W  codes lost to full holding register, saturating

Behaviour:
- Clock and reset: one clock, clk_in. Reset is asynchronous and active-low on rst_n_in, and all flops clear immediately on assertion.
- Reset values:
  - Sync flops and edge-history flops: all 1 (no spurious fall).
  - state = SCAN, rr_ptr = 0.
  - dec_data_out = 1, dec_rst_out = 1, code_out = 0, chan_out = 0, code_valid_out = 0, drop_count_out = 0, counters = 0.
  - dec_rst_out drops to 0 on the first clock after release.
- Input path: each line passes through a 2-flop synchroniser plus a history flop. fall[i] = hist[i] & ~sync[i].
- SCAN:
  - dec_data_out <= 1.
  - If any fall exists, grant the first set bit searching from rr_ptr upward with wrap. Set g = index, state <= LOCK, counters cleared, and dec_data_out <= sync[g] (0) in the same cycle.
  - Simultaneous falls: only the winner is served. Losers are ignored; their mid-frame edges seen later are rejected by the decoder's length checks.
- LOCK:
  - dec_data_out <= sync[g] every cycle, giving a fixed 3-cycle latency from lines_in and preserving pulse widths.
  - frame_cnt increments each cycle.
  - high_cnt increments while sync[g] = 1 and clears on 0.
  - On dec_new_code_in:
    - Capture into the holding register if !code_valid_out or (code_ready_in this cycle): code_out <= dec_code_in, chan_out <= g, code_valid_out <= 1.
    - Otherwise increment drop_count_out, saturating at all-ones.
    - rr_ptr <= g+1 (wrap), state <= SCAN.
  - Otherwise, if high_cnt == HIGH_TIMEOUT or frame_cnt == FRAME_TIMEOUT: state <= RELEASE and rr_ptr <= g+1.
  - new_code has priority over a timeout in the same cycle.
- RELEASE:
  - One cycle with dec_rst_out = 1 and dec_data_out = 1, then SCAN.
  - Falls during RELEASE are not latched; they are missed.
- Output handshake:
  - code_valid_out clears on valid&ready unless a new capture occurs in the same cycle; the capture wins and valid stays 1.
  - code_out and chan_out are stable while valid & !ready.
- busy_out = (state != SCAN), registered along with state.
- Reset mid-frame: immediate return to reset values, with the decoder held in reset through dec_rst_out.

Optional Feature:
- Macro RX_SCHED_LINE_MASK_EN.
- Defined:
  - Adds input port line_mask_in [NUM_LINES-1:0]. A 1 disables the line: it is excluded from grant in SCAN.
  - Masking the currently locked line forces LOCK -> RELEASE on the next cycle. rr_ptr advances as on a timeout.
- Undefined: the port is absent and all lines are always eligible.

Test Plan:
- Reset and idle: lines all high, reset held 5 cycles → dec_rst_out=1 during reset and 0 after; code_valid_out=0; busy_out=0; no grant.
- Single frame: line 2 sends code 26'h2AA_AAAA at DATA_PERIOD=20, ready held high, decoder model attached → code_out=26'h2AA_AAAA, chan_out=2, one valid cycle; dec_data_out equals lines_in[2] delayed 3 cycles.
- Round-robin: lines 0 and 3 fall in the same cycle, rr_ptr=0 → line 0 granted. Next simultaneous falls on lines 0 and 3 → line 3 granted.
- Backpressure: ready=0, two frames complete (codes 26'h1, 26'h2) → code_out holds 26'h1, drop_count_out=1. Raise ready → valid clears.
- Timeout: line 1 falls then stays high for 40 cycles → RELEASE at high_cnt=32, dec_rst_out pulses 1 cycle, rr_ptr=2, no valid output.
- Mask (RX_SCHED_LINE_MASK_EN defined): mask=4'b0010, line 1 sends a frame → no grant. Masking line 0 mid-frame → RELEASE on the next cycle.
